// File: rtl/song_recorder.sv
// Records chord changes from the key inputs as {note_mask, duration} entries and serves them on a registered read port.
// Optional build macro REC_DROP_RESTS_EN: all-released periods extend the preceding entry instead of being stored.
module song_recorder #(
    parameter int DEPTH    = 16,
    parameter int ADDRW    = 4,
    parameter int DURW     = 8,
    parameter int TICK_DIV = 250000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          keys,
    input  logic                rec_en,
    input  logic [ADDRW-1:0]    rd_addr,
    output logic [8+DURW-1:0]   rd_data,
    output logic [ADDRW:0]      length,
    output logic                busy,
    output logic                full,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

    localparam int CNTW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(TICK_DIV - 1);
    localparam logic [DURW-1:0]  DUR_MAX  = '1;
    localparam logic [ADDRW:0]   LEN_MAX  = (ADDRW + 1)'(DEPTH);

    state_t             state, state_next;
    logic [CNTW-1:0]    cnt;
    logic [DURW-1:0]    dur, dur_next, dur_inc;
    logic [7:0]         cur_mask, cur_mask_next;
    logic [ADDRW:0]     length_next;
    logic               rec_prev, rec_rise, tick;
    logic               wr_en;
    logic [ADDRW-1:0]   wr_addr;
    logic [8+DURW-1:0]  wr_data;
    logic [8+DURW-1:0]  mem [DEPTH];
`ifdef REC_DROP_RESTS_EN
    logic [7:0]         last_mask, last_mask_next;
    logic [DURW-1:0]    last_dur, last_dur_next;
`endif

    assign tick     = (state == RECORD) && (cnt == CNT_LAST);
    assign rec_rise = rec_en && !rec_prev;
    // dur never rests at all-ones (saturation writes it back to 0), so this cannot wrap
    assign dur_inc  = dur + DURW'(tick);

    assign busy = (state == ARMED) || (state == RECORD);
    assign done = (state == DONE);
    assign full = (length == LEN_MAX);

    always_comb begin
        state_next    = state;
        length_next   = length;
        cur_mask_next = cur_mask;
        dur_next      = dur;
        wr_en         = 1'b0;
        wr_addr       = length[ADDRW-1:0];
        wr_data       = {cur_mask, dur_inc};
`ifdef REC_DROP_RESTS_EN
        last_mask_next = last_mask;
        last_dur_next  = last_dur;
`endif
        case (state)
            IDLE: begin
                if (rec_rise) begin
                    length_next = '0;
                    state_next  = ARMED;
                end
            end
            ARMED: begin
                if (!rec_en) begin
                    length_next = '0;
                    state_next  = IDLE;
                end else if (keys != 8'h00) begin
                    cur_mask_next = keys;
                    dur_next      = '0;
                    state_next    = RECORD;
                end
            end
            RECORD: begin
`ifdef REC_DROP_RESTS_EN
                // During a rest every tick is folded into the previous entry in place
                if (cur_mask == 8'h00) begin
                    if (tick && length != '0) begin
                        last_dur_next = (last_dur == DUR_MAX) ? last_dur : last_dur + DURW'(1);
                        wr_en         = 1'b1;
                        wr_addr       = length[ADDRW-1:0] - ADDRW'(1);
                        wr_data       = {last_mask, last_dur_next};
                    end
                    if (!rec_en) begin
                        state_next = DONE;
                    end else if (keys != cur_mask) begin
                        cur_mask_next = keys;
                        dur_next      = '0;
                    end
                end else
`endif
                begin
                    if (!rec_en) begin
                        wr_en      = (dur_inc != '0);
                        state_next = DONE;
                    end else if (keys != cur_mask) begin
                        wr_en         = 1'b1;
                        cur_mask_next = keys;
                        dur_next      = '0;
                    end else if (tick && dur_inc == DUR_MAX) begin
                        wr_en    = 1'b1;
                        dur_next = '0;
                    end else begin
                        dur_next = dur_inc;
                    end
                    if (wr_en) begin
                        length_next = length + (ADDRW + 1)'(1);
                        if (length_next == LEN_MAX) state_next = DONE;
`ifdef REC_DROP_RESTS_EN
                        last_mask_next = cur_mask;
                        last_dur_next  = dur_inc;
`endif
                    end
                end
            end
            DONE: begin
                if (rec_rise) begin
                    length_next = '0;
                    state_next  = ARMED;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            length   <= '0;
            cur_mask <= 8'h00;
            dur      <= '0;
            cnt      <= '0;
            rec_prev <= 1'b0;
            rd_data  <= '0;
`ifdef REC_DROP_RESTS_EN
            last_mask <= 8'h00;
            last_dur  <= '0;
`endif
        end else begin
            state    <= state_next;
            length   <= length_next;
            cur_mask <= cur_mask_next;
            dur      <= dur_next;
            cnt      <= (state == RECORD && !tick) ? cnt + CNTW'(1) : '0;
            rec_prev <= rec_en;
            rd_data  <= mem[rd_addr];
`ifdef REC_DROP_RESTS_EN
            last_mask <= last_mask_next;
            last_dur  <= last_dur_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: two instances (long and short configurations) share stimulus; a segment-level model predicts the song.
module tb_song_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rec_en;
    logic [7:0]  keys;
    logic [3:0]  rd_addr;

    logic [15:0] rd_data_a;
    logic [4:0]  length_a;
    logic        busy_a, full_a, done_a;
    logic [11:0] rd_data_b;
    logic [2:0]  length_b;
    logic        busy_b, full_b, done_b;

    int checks = 0;
    int passed = 0;

    // Recording session description: mask held for seg_len clock edges each
    int          seg_cnt;
    logic [7:0]  seg_mask [0:15];
    int          seg_len  [0:15];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    song_recorder #(.DEPTH(16), .ADDRW(4), .DURW(8), .TICK_DIV(4)) u_a (
        .clk(clk), .reset(reset), .keys(keys), .rec_en(rec_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .length(length_a), .busy(busy_a), .full(full_a), .done(done_a)
    );

    song_recorder #(.DEPTH(4), .ADDRW(2), .DURW(4), .TICK_DIV(2)) u_b (
        .clk(clk), .reset(reset), .keys(keys), .rec_en(rec_en), .rd_addr(rd_addr[1:0]),
        .rd_data(rd_data_b), .length(length_b), .busy(busy_b), .full(full_b), .done(done_b)
    );

    // Ticks fall on RECORD edges k = t_div, 2*t_div, ...; a segment owns the ticks in (start, end].
    task automatic model_song(input int t_div, input int maxdur, input int depth);
        int s, e, n, k, d, last;
        exp_q.delete();
        s = 0;
        for (int i = 0; i < seg_cnt; i++) begin
            if (exp_q.size() >= depth) break;
            e = s + seg_len[i];
            n = e / t_div - s / t_div;
`ifdef REC_DROP_RESTS_EN
            if (seg_mask[i] == 8'h00) begin
                if (exp_q.size() > 0) begin
                    last = exp_q.size() - 1;
                    d = int'(exp_q[last][7:0]) + n;
                    if (d > maxdur) d = maxdur;
                    exp_q[last] = {exp_q[last][15:8], 8'(d)};
                end
                s = e;
                continue;
            end
`endif
            k = (n + maxdur - 1) / maxdur;
            if (k == 0 && i != seg_cnt - 1) k = 1;
            for (int j = 0; j < k; j++) begin
                d = (j < k - 1) ? maxdur : n - maxdur * (k - 1);
                if (exp_q.size() < depth) exp_q.push_back({seg_mask[i], 8'(d)});
            end
            s = e;
        end
    endtask

    task automatic run_session(input string name);
        @(negedge clk);
        rec_en = 1'b1;
        keys   = 8'h00;
        @(negedge clk);
        keys = seg_mask[0];
        for (int i = 0; i < seg_cnt; i++) begin
            repeat (seg_len[i]) @(negedge clk);
            if (i < seg_cnt - 1) keys = seg_mask[i + 1];
        end
        rec_en = 1'b0;
        repeat (3) @(negedge clk);
        keys = 8'h00;

        model_song(4, 255, 16);
        checks++;
        if (length_a !== 5'(exp_q.size()))
            $display("FAIL %s length_a: got %0d want %0d", name, length_a, exp_q.size());
        else passed++;
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || full_a !== (exp_q.size() == 16))
            $display("FAIL %s flags_a: got done=%b busy=%b full=%b want done=1 busy=0 full=%b",
                     name, done_a, busy_a, full_a, exp_q.size() == 16);
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            checks++;
            if (rd_data_a !== exp_q[i])
                $display("FAIL %s entry_a[%0d]: got %h want %h", name, i, rd_data_a, exp_q[i]);
            else passed++;
        end

        model_song(2, 15, 4);
        checks++;
        if (length_b !== 3'(exp_q.size()))
            $display("FAIL %s length_b: got %0d want %0d", name, length_b, exp_q.size());
        else passed++;
        checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || full_b !== (exp_q.size() == 4))
            $display("FAIL %s flags_b: got done=%b busy=%b full=%b want done=1 busy=0 full=%b",
                     name, done_b, busy_b, full_b, exp_q.size() == 4);
        else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            checks++;
            if (rd_data_b !== {exp_q[i][15:8], exp_q[i][3:0]})
                $display("FAIL %s entry_b[%0d]: got %h want %h", name, i, rd_data_b,
                         {exp_q[i][15:8], exp_q[i][3:0]});
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rec_en  = 1'b0;
        keys    = 8'h00;
        rd_addr = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (length_a !== 5'd0 || rd_data_a !== 16'h0 || busy_a !== 1'b0 || full_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL reset_a: got len=%0d rd=%h busy=%b full=%b done=%b want all zero",
                     length_a, rd_data_a, busy_a, full_a, done_a);
        else passed++;
        checks++;
        if (length_b !== 3'd0 || rd_data_b !== 12'h0 || busy_b !== 1'b0 || full_b !== 1'b0 || done_b !== 1'b0)
            $display("FAIL reset_b: got len=%0d rd=%h busy=%b full=%b done=%b want all zero",
                     length_b, rd_data_b, busy_b, full_b, done_b);
        else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        seg_cnt = 2;
        seg_mask[0] = 8'hA8; seg_len[0] = 40;
        seg_mask[1] = 8'h01; seg_len[1] = 20;
        run_session("basic");
    endtask

    task automatic test_saturation();
        seg_cnt = 1;
        seg_mask[0] = 8'h08; seg_len[0] = 70;
        run_session("saturation");
    endtask

    task automatic test_full();
        seg_cnt = 6;
        for (int i = 0; i < 6; i++) begin
            seg_mask[i] = (i % 2 == 0) ? 8'h01 : 8'h02;
            seg_len[i]  = 5;
        end
        run_session("full");
    endtask

    task automatic test_rests();
        seg_cnt = 3;
        seg_mask[0] = 8'h20; seg_len[0] = 32;
        seg_mask[1] = 8'h00; seg_len[1] = 16;
        seg_mask[2] = 8'h40; seg_len[2] = 16;
        run_session("rests");
    endtask

    task automatic test_abort();
        @(negedge clk);
        rec_en = 1'b1;
        keys   = 8'h00;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || length_a !== 5'd0 ||
            busy_b !== 1'b1 || done_b !== 1'b0 || length_b !== 3'd0)
            $display("FAIL abort_armed: got busy=%b/%b done=%b/%b len=%0d/%0d want busy=1 done=0 len=0",
                     busy_a, busy_b, done_a, done_b, length_a, length_b);
        else passed++;
        rec_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || length_a !== 5'd0 ||
            busy_b !== 1'b0 || done_b !== 1'b0 || length_b !== 3'd0)
            $display("FAIL abort_idle: got busy=%b/%b done=%b/%b len=%0d/%0d want all zero",
                     busy_a, busy_b, done_a, done_b, length_a, length_b);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rd_addr = 4'd0;
        @(negedge clk);
        rec_en = 1'b1;
        @(negedge clk);
        keys = 8'h11;
        repeat (12) @(negedge clk);
        keys = 8'h22;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (length_a !== 5'd0 || rd_data_a !== 16'h0 || busy_a !== 1'b0 || done_a !== 1'b0)
            $display("FAIL reset_mid_a: got len=%0d rd=%h busy=%b done=%b want all zero",
                     length_a, rd_data_a, busy_a, done_a);
        else passed++;
        checks++;
        if (length_b !== 3'd0 || rd_data_b !== 12'h0 || busy_b !== 1'b0 || done_b !== 1'b0)
            $display("FAIL reset_mid_b: got len=%0d rd=%h busy=%b done=%b want all zero",
                     length_b, rd_data_b, busy_b, done_b);
        else passed++;
        rec_en = 1'b0;
        keys   = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0)
            $display("FAIL reset_mid_idle: got busy=%b/%b done=%b/%b want 0",
                     busy_a, busy_b, done_a, done_b);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] m;
        for (int r = 0; r < 5; r++) begin
            seg_cnt = $urandom_range(2, 6);
            for (int i = 0; i < seg_cnt; i++) begin
                do m = 8'($urandom_range(0, 255));
                while ((i == 0 && m == 8'h00) || (i > 0 && m == seg_mask[i - 1]));
                if (i > 0 && $urandom_range(0, 3) == 0 && seg_mask[i - 1] != 8'h00) m = 8'h00;
                seg_mask[i] = m;
                seg_len[i]  = $urandom_range(1, 40);
            end
            run_session($sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_full();
        test_rests();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
